pwm_level_ctrl: RTL and testbench
=================================

PWM_LEVEL_CTRL -- requirements
Module: pwm_level_ctrl

Interface
REQ-001 SHALL have parameter CH, default 2: number of independent PWM channels.
REQ-002 SHALL have parameter LW, default 3: duty-level width per channel.
REQ-003 SHALL have parameter PW, default 8: period-counter width; PW >= LW required.
REQ-004 SHALL have parameter DB_CYC, default 16: consecutive stable cycles for button acceptance.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port btn_up  input  CH  per-channel increment button, active-low, asynchronous.
REQ-008 SHALL have port btn_dn  input  CH  per-channel decrement button, active-low, asynchronous.
REQ-009 SHALL have port top  input  LW  maximum level, shared by all channels.
REQ-010 SHALL have port wrap  input  1  1 = wrap at limits, 0 = saturate.
REQ-011 SHALL have port tick  input  1  period-counter advance enable.
REQ-012 SHALL have port level  output  CH*LW  live level per channel, channel i at bits [i*LW +: LW].
REQ-013 SHALL have port pwm  output  CH  registered PWM output per channel.
REQ-014 SHALL have port period_end  output  1  one-cycle pulse at period wrap.

Function
REQ-015 Each button SHALL pass a 2-FF synchroniser, then a debouncer that copies the synchronised value only after DB_CYC consecutive cycles of disagreement; shorter bounces are rejected.
REQ-016 A press SHALL be a debounced 1->0 transition, emitted as a one-cycle event; release produces no event.
REQ-017 Level SHALL change exactly DB_CYC+3 cycles after the first clock edge sampling a steady low button.
REQ-018 Up event alone: level < top -> level+1; level == top -> 0 if wrap, else stays top.
REQ-019 Down event alone: level > 0 -> level-1; level == 0 -> top if wrap, else stays 0.
REQ-020 Up and down events on the same channel in the same cycle SHALL leave the level unchanged.
REQ-021 If level > top (top lowered), level SHALL become top on the next cycle; this clamp overrides button events.
REQ-022 top == 0 SHALL hold every level at 0.
REQ-023 Period counter cnt (PW bits) SHALL increment when tick = 1 and wrap from 2^PW-1 to 0.
REQ-024 period_end SHALL be 1 for exactly the cycle in which tick = 1 and cnt == 2^PW-1.
REQ-025 Each channel SHALL hold a shadow level loaded from level only in cycles where period_end = 1; mid-period level changes SHALL NOT affect the current period.
REQ-026 pwm[i] SHALL be registered as (cnt < shadow[i] << (PW-LW)), i.e. one cycle behind cnt; shadow 0 gives constant 0, and maximum level is below 100 %.

Reset
REQ-027 On rst: level, shadow, cnt, pwm, period_end SHALL be 0; synchroniser and debounced states SHALL be 1 (released); debounce counters SHALL be 0.
REQ-028 rst mid-press SHALL discard the pending press; the button SHALL be released (debounced) and pressed again to generate a new event.

Structure
REQ-029 Package pwm_pkg SHALL hold default CH, LW, PW, DB_CYC constants and a typedef for the wrap/saturate mode.
REQ-030 Sub-module btn_debounce (synchroniser, debouncer, falling-edge event) SHALL be instantiated 2*CH times; the level, shadow and compare logic remain in pwm_level_ctrl.

Verification
REQ-031 CH=2, top=5, wrap=0: six up presses on ch0 -> level0 = 1..5 then stays 5; ch1 stays 0.
REQ-032 wrap=1, top=5, level=5: one up press -> 0; then one down press -> 5.
REQ-033 btn_up low for DB_CYC-1 cycles, then high -> level unchanged; held low for DB_CYC+5 cycles -> +1 exactly DB_CYC+3 cycles after first low sample.
REQ-034 Level=6, top lowered to 2 -> level = 2 on the next cycle; an up press in that same cycle is ignored.
REQ-035 tick=1 every cycle, PW=8, LW=3, level=4 -> period_end every 256 cycles; pwm high for 128 cycles per period; a change to 2 mid-period applies only from the next period (64 cycles).
REQ-036 rst asserted during a debounce in progress -> all outputs 0 next cycle; no level change after rst is released until a new full press.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults and types for the multi-channel PWM level controller.
package pwm_pkg;

  localparam int DEF_CH     = 2;
  localparam int DEF_LW     = 3;
  localparam int DEF_PW     = 8;
  localparam int DEF_DB_CYC = 16;

  typedef enum logic {
    LIMIT_SAT  = 1'b0,
    LIMIT_WRAP = 1'b1
  } limit_mode_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low asynchronous button -> 2-FF synchroniser -> debouncer -> one-cycle press event.
// After reset the button must be seen released for DB_CYC cycles before a press can be accepted.
module btn_debounce
  import pwm_pkg::*;
#(
  parameter int DB_CYC = DEF_DB_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int            CW       = cnt_width(DB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d, db_dly_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d   = '0;
    db_d    = db_q;
    armed_d = armed_q;
    if (!armed_q) begin
      // Unarmed: the counter measures a steady release instead of a disagreement.
      if (sync2_q) begin
        if (cnt_q == CNT_LAST) armed_d = 1'b1;
        else                   cnt_d   = cnt_q + CW'(1);
      end
    end else if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) db_d  = sync2_q;
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      press_q  <= db_dly_q & ~db_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pwm_level_ctrl.sv
// Per-channel up/down level registers driving PWM outputs from one shared period counter.
// Levels are latched into shadow registers at period wrap; PW must be >= LW.
module pwm_level_ctrl
  import pwm_pkg::*;
#(
  parameter int CH     = DEF_CH,
  parameter int LW     = DEF_LW,
  parameter int PW     = DEF_PW,
  parameter int DB_CYC = DEF_DB_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     btn_up,
  input  logic [CH-1:0]     btn_dn,
  input  logic [LW-1:0]     top,
  input  logic              wrap,
  input  logic              tick,
  output logic [CH*LW-1:0]  level,
  output logic [CH-1:0]     pwm,
  output logic              period_end
);

  limit_mode_e   mode;
  logic [CH-1:0] up_ev, dn_ev;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [CH-1:0] pwm_q, pwm_d;
  logic [LW-1:0] level_q  [CH];
  logic [LW-1:0] level_d  [CH];
  logic [LW-1:0] shadow_q [CH];
  logic [LW-1:0] shadow_d [CH];

  assign mode       = limit_mode_e'(wrap);
  assign period_end = tick && (cnt_q == '1);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    btn_debounce #(.DB_CYC(DB_CYC)) u_up (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (btn_up[g]),
      .press_o (up_ev[g])
    );
    btn_debounce #(.DB_CYC(DB_CYC)) u_dn (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (btn_dn[g]),
      .press_o (dn_ev[g])
    );
    assign level[g*LW +: LW] = level_q[g];
  end

  always_comb begin
    cnt_d = tick ? cnt_q + PW'(1) : cnt_q;
    pwm_d = '0;
    for (int i = 0; i < CH; i++) begin
      level_d[i]  = level_q[i];
      shadow_d[i] = period_end ? level_q[i] : shadow_q[i];
      pwm_d[i]    = cnt_q < (PW'(shadow_q[i]) << (PW - LW));
      // Clamp after a lowered top wins over any button event this cycle.
      if (level_q[i] > top) begin
        level_d[i] = top;
      end else if (up_ev[i] && !dn_ev[i]) begin
        if (level_q[i] == top) level_d[i] = (mode == LIMIT_WRAP) ? '0 : top;
        else                   level_d[i] = level_q[i] + LW'(1);
      end else if (dn_ev[i] && !up_ev[i]) begin
        if (level_q[i] == '0) level_d[i] = (mode == LIMIT_WRAP) ? top : '0;
        else                  level_d[i] = level_q[i] - LW'(1);
      end
    end
  end

  // NOTE: these per-channel arrays are plain flops, not a RAM, so they take the reset like any register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= '0;
      for (int i = 0; i < CH; i++) begin
        level_q[i]  <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      for (int i = 0; i < CH; i++) begin
        level_q[i]  <= level_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_level_ctrl.sv
// Directed bench for pwm_level_ctrl: a level model feeds a scoreboard queue, outputs checked by assertions.
module tb_pwm_level_ctrl;

  localparam int CH     = 2;
  localparam int LW     = 3;
  localparam int PW     = 8;
  localparam int DB_CYC = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     btn_up, btn_dn;
  logic [LW-1:0]     top;
  logic              wrap, tick;
  logic [CH*LW-1:0]  level;
  logic [CH-1:0]     pwm;
  logic              period_end;

  int checks   = 0;
  int failures = 0;
  int lvl_m [CH];
  logic [CH*LW-1:0] exp_q [$];

  pwm_level_ctrl #(.CH(CH), .LW(LW), .PW(PW), .DB_CYC(DB_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .top        (top),
    .wrap       (wrap),
    .tick       (tick),
    .level      (level),
    .pwm        (pwm),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int model_next(input int lvl, input bit up, input bit dn);
    int t;
    t = int'(top);
    if (lvl > t) return t;
    if (up && !dn) return (lvl == t) ? (wrap ? 0 : t) : lvl + 1;
    if (dn && !up) return (lvl == 0) ? (wrap ? t : 0) : lvl - 1;
    return lvl;
  endfunction

  task automatic sb_push();
    logic [CH*LW-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v[i*LW +: LW] = LW'(lvl_m[i]);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag);
    logic [CH*LW-1:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(level), 32'(e));
  endtask

  // Full press/release on one channel; level is compared DB_CYC+3 cycles after the first low sample.
  task automatic press(input int ch, input bit up, input bit dn, input string tag);
    btn_up[ch] = ~up;
    btn_dn[ch] = ~dn;
    lvl_m[ch]  = model_next(lvl_m[ch], up, dn);
    sb_push();
    step(DB_CYC + 4);
    sb_check(tag);
    btn_up[ch] = 1'b1;
    btn_dn[ch] = 1'b1;
    step(DB_CYC + 4);
  endtask

  task automatic measure(input bit presses, output int hi0, output int hi1, output int pe);
    hi0 = 0;
    hi1 = 0;
    pe  = 0;
    for (int i = 0; i < 256; i++) begin
      if (presses) begin
        case (i)
          10:  btn_dn[0] = 1'b0;
          40:  btn_dn[0] = 1'b1;
          80:  btn_dn[0] = 1'b0;
          110: btn_dn[0] = 1'b1;
          default: ;
        endcase
      end
      step(1);
      hi0 += int'(pwm[0]);
      hi1 += int'(pwm[1]);
      pe  += int'(period_end);
    end
  endtask

  initial begin
    int guard;
    int hi0, hi1, pe;

    rst    = 1'b1;
    btn_up = '1;
    btn_dn = '1;
    top    = 3'd5;
    wrap   = 1'b0;
    tick   = 1'b0;
    for (int i = 0; i < CH; i++) lvl_m[i] = 0;
    step(2);
    check("rst_level", 32'(level), 0);
    check("rst_pwm", 32'(pwm), 0);
    check("rst_period_end", 32'(period_end), 0);
    rst = 1'b0;
    step(DB_CYC + 4);

    // Saturating ramp on ch0, ch1 untouched.
    for (int k = 0; k < 6; k++) press(0, 1'b1, 1'b0, $sformatf("sat_up_%0d", k));

    // Wrap at both limits.
    wrap = 1'b1;
    press(0, 1'b1, 1'b0, "wrap_up_top");
    press(0, 1'b0, 1'b1, "wrap_dn_zero");

    // Short bounce rejected on ch1.
    btn_up[1] = 1'b0;
    step(DB_CYC - 1);
    btn_up[1] = 1'b1;
    step(2 * DB_CYC);
    sb_push();
    sb_check("short_bounce");

    // Exact acceptance latency on ch1, held low DB_CYC+5 cycles.
    btn_up[1] = 1'b0;
    sb_push();
    step(DB_CYC + 3);
    sb_check("latency_before");
    lvl_m[1] = model_next(lvl_m[1], 1'b1, 1'b0);
    sb_push();
    step(1);
    sb_check("latency_edge");
    step(1);
    btn_up[1] = 1'b1;
    step(DB_CYC + 4);
    sb_push();
    sb_check("release_no_event");

    press(1, 1'b1, 1'b1, "up_dn_same_cycle");

    // Lowering top clamps in the same cycle an up event arrives.
    top  = 3'd7;
    wrap = 1'b0;
    press(0, 1'b1, 1'b0, "to_six");
    btn_up[0] = 1'b0;
    step(DB_CYC + 3);
    top = 3'd2;
    for (int i = 0; i < CH; i++) lvl_m[i] = model_next(lvl_m[i], 1'b0, 1'b0);
    sb_push();
    step(1);
    sb_check("clamp_edge");
    sb_push();
    step(1);
    sb_check("clamp_hold");
    btn_up[0] = 1'b1;
    step(DB_CYC + 4);

    top = 3'd0;
    for (int i = 0; i < CH; i++) lvl_m[i] = model_next(lvl_m[i], 1'b0, 1'b0);
    sb_push();
    step(1);
    sb_check("top_zero");
    press(0, 1'b1, 1'b0, "top_zero_press");

    top = 3'd7;
    for (int k = 0; k < 4; k++) press(0, 1'b1, 1'b0, $sformatf("ramp_%0d", k));

    // PWM: first wrap arrives after 255 ticks from cnt = 0.
    tick  = 1'b1;
    guard = 0;
    do begin
      step(1);
      guard++;
    end while (!period_end && guard < 600);
    check("first_period_end", 32'(period_end), 1);
    check("first_period_len", 32'(guard), 255);

    measure(1'b0, hi0, hi1, pe);
    check("p1_high_cycles", 32'(hi0), 128);
    check("p1_ch1_high", 32'(hi1), 0);
    check("p1_pulses", 32'(pe), 1);
    check("p1_end", 32'(period_end), 1);

    measure(1'b1, hi0, hi1, pe);
    lvl_m[0] = model_next(model_next(lvl_m[0], 1'b0, 1'b1), 1'b0, 1'b1);
    sb_push();
    sb_check("mid_period_level");
    check("p2_high_cycles", 32'(hi0), 128);
    check("p2_pulses", 32'(pe), 1);

    measure(1'b0, hi0, hi1, pe);
    check("p3_high_cycles", 32'(hi0), 64);
    check("p3_end", 32'(period_end), 1);

    // Reset during a pending press: outputs clear, no event until a fresh press.
    btn_up[0] = 1'b0;
    step(8);
    rst = 1'b1;
    step(1);
    check("midrst_level", 32'(level), 0);
    check("midrst_pwm", 32'(pwm), 0);
    check("midrst_period_end", 32'(period_end), 0);
    rst = 1'b0;
    for (int i = 0; i < CH; i++) lvl_m[i] = 0;
    step(3 * DB_CYC);
    sb_push();
    sb_check("post_rst_held");
    btn_up[0] = 1'b1;
    step(DB_CYC + 4);
    press(0, 1'b1, 1'b0, "post_rst_press");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
